// File: rtl/jr_redirect_ctrl.sv
// jr_redirect_ctrl
//   Resolves a register-indirect jump (jr) sitting in ID. While the rs
//   operand is still being produced by an older instruction in EX or MEM the
//   front end is stalled. Once the operand is available the word-aligned
//   target is captured and, one cycle later, the PC is redirected and IF/ID
//   is flushed.
//
// Ports
//   Clk, Reset_n              clock, asynchronous active-low reset
//   JrValid_ID                a jr occupies ID
//   JrRs_ID, ReadData1_ID     rs index of the jr and its register-file data
//   RegWrite_EX/MEM           write enables of the instructions in EX / MEM
//   WriteReg_EX/MEM           destination registers of EX / MEM
//   BranchTaken_EX            an older branch redirects the PC this cycle
//   Stall                     hold PC and IF/ID, bubble into ID/EX
//   PCSelJr                   PC loads JrTarget at the next edge
//   JrTarget                  registered, word-aligned jump target
//   Flush_IFID                zero the IF/ID register
//   JrAddrErr                 one-cycle pulse: captured target was misaligned
//   JrStallCnt                saturating count of Stall cycles

module jr_redirect_ctrl (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        JrValid_ID,
    input  logic [4:0]  JrRs_ID,
    input  logic [31:0] ReadData1_ID,
    input  logic        RegWrite_EX,
    input  logic        RegWrite_MEM,
    input  logic [4:0]  WriteReg_EX,
    input  logic [4:0]  WriteReg_MEM,
    input  logic        BranchTaken_EX,
    output logic        Stall,
    output logic        PCSelJr,
    output logic [31:0] JrTarget,
    output logic        Flush_IFID,
    output logic        JrAddrErr,
    output logic [15:0] JrStallCnt
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRedir
    } state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_target;
    logic        r_addr_err;
    logic [15:0] r_stall_cnt;
    logic        w_hazard;
    logic        w_stall;
    logic        w_capture;

    // WB writers are not hazards: the register file is write-first.
    assign w_hazard = (JrRs_ID != 5'd0) &&
                      ((RegWrite_EX  && (WriteReg_EX  == JrRs_ID)) ||
                       (RegWrite_MEM && (WriteReg_MEM == JrRs_ID)));

    always_comb begin
        w_state_nxt = r_state;
        w_stall     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            StIdle: begin
                // A jr behind a taken branch is younger and will be flushed.
                if (JrValid_ID && !BranchTaken_EX) begin
                    w_stall = 1'b1;
                    if (w_hazard) begin
                        w_state_nxt = StWait;
                    end else begin
                        w_capture   = 1'b1;
                        w_state_nxt = StRedir;
                    end
                end
            end
            StWait: begin
                if (BranchTaken_EX || !JrValid_ID) begin
                    w_state_nxt = StIdle;
                end else begin
                    w_stall = 1'b1;
                    if (!w_hazard) begin
                        w_capture   = 1'b1;
                        w_state_nxt = StRedir;
                    end
                end
            end
            StRedir: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= StIdle;
            r_target    <= 32'd0;
            r_addr_err  <= 1'b0;
            r_stall_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_target   <= {ReadData1_ID[31:2], 2'b00};
                r_addr_err <= (ReadData1_ID[1:0] != 2'b00);
            end
            if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    // Stall is combinational from ID inputs; gate it so reset forces it low.
    assign Stall      = w_stall && Reset_n;
    assign PCSelJr    = (r_state == StRedir);
    assign Flush_IFID = (r_state == StRedir);
    assign JrAddrErr  = (r_state == StRedir) && r_addr_err;
    assign JrTarget   = r_target;
    assign JrStallCnt = r_stall_cnt;

endmodule

// File: tb/tb_jr_redirect_ctrl.sv
// tb_jr_redirect_ctrl
//   Directed bench for jr_redirect_ctrl. Inputs change 1 time unit after a
//   rising edge; outputs are checked 1 more unit later, well away from edges.

module tb_jr_redirect_ctrl;

    logic        Clk;
    logic        Reset_n;
    logic        JrValid_ID;
    logic [4:0]  JrRs_ID;
    logic [31:0] ReadData1_ID;
    logic        RegWrite_EX;
    logic        RegWrite_MEM;
    logic [4:0]  WriteReg_EX;
    logic [4:0]  WriteReg_MEM;
    logic        BranchTaken_EX;
    logic        Stall;
    logic        PCSelJr;
    logic [31:0] JrTarget;
    logic        Flush_IFID;
    logic        JrAddrErr;
    logic [15:0] JrStallCnt;

    int n_vec = 0;
    int n_err = 0;

    jr_redirect_ctrl u_dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .JrValid_ID     (JrValid_ID),
        .JrRs_ID        (JrRs_ID),
        .ReadData1_ID   (ReadData1_ID),
        .RegWrite_EX    (RegWrite_EX),
        .RegWrite_MEM   (RegWrite_MEM),
        .WriteReg_EX    (WriteReg_EX),
        .WriteReg_MEM   (WriteReg_MEM),
        .BranchTaken_EX (BranchTaken_EX),
        .Stall          (Stall),
        .PCSelJr        (PCSelJr),
        .JrTarget       (JrTarget),
        .Flush_IFID     (Flush_IFID),
        .JrAddrErr      (JrAddrErr),
        .JrStallCnt     (JrStallCnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr_in();
        JrValid_ID     = 1'b0;
        JrRs_ID        = 5'd0;
        ReadData1_ID   = 32'd0;
        RegWrite_EX    = 1'b0;
        RegWrite_MEM   = 1'b0;
        WriteReg_EX    = 5'd0;
        WriteReg_MEM   = 5'd0;
        BranchTaken_EX = 1'b0;
    endtask

    task automatic do_reset();
        clr_in();
        Reset_n = 1'b0;
        #3;
        Reset_n = 1'b1;
    endtask

    task automatic jr(input logic [4:0] rs, input logic [31:0] data);
        JrValid_ID   = 1'b1;
        JrRs_ID      = rs;
        ReadData1_ID = data;
    endtask

    initial begin
        clr_in();
        Reset_n = 1'b0;
        #2;
        chk("rst_stall", {31'd0, Stall}, 32'd0);
        chk("rst_pcsel", {31'd0, PCSelJr}, 32'd0);
        chk("rst_target", JrTarget, 32'd0);
        chk("rst_cnt", {16'd0, JrStallCnt}, 32'd0);
        #10;
        Reset_n = 1'b1;

        // No hazard: one stall cycle, then REDIR.
        tick();
        jr(5'd5, 32'h0040_0100);
        #1;
        chk("nh_stall", {31'd0, Stall}, 32'd1);
        chk("nh_pcsel0", {31'd0, PCSelJr}, 32'd0);
        tick();
        clr_in();
        #1;
        chk("nh_pcsel", {31'd0, PCSelJr}, 32'd1);
        chk("nh_flush", {31'd0, Flush_IFID}, 32'd1);
        chk("nh_stall_r", {31'd0, Stall}, 32'd0);
        chk("nh_target", JrTarget, 32'h0040_0100);
        chk("nh_cnt", {16'd0, JrStallCnt}, 32'd1);
        chk("nh_aerr", {31'd0, JrAddrErr}, 32'd0);
        tick();
        #1;
        chk("nh_pcsel_end", {31'd0, PCSelJr}, 32'd0);
        chk("nh_flush_end", {31'd0, Flush_IFID}, 32'd0);

        // EX hazard, then MEM hazard, then capture.
        do_reset();
        tick();
        jr(5'd5, 32'h0040_0200);
        RegWrite_EX = 1'b1;
        WriteReg_EX = 5'd5;
        #1;
        chk("ex_stall1", {31'd0, Stall}, 32'd1);
        tick();
        RegWrite_EX  = 1'b0;
        RegWrite_MEM = 1'b1;
        WriteReg_MEM = 5'd5;
        #1;
        chk("ex_stall2", {31'd0, Stall}, 32'd1);
        chk("ex_pcsel2", {31'd0, PCSelJr}, 32'd0);
        tick();
        RegWrite_MEM = 1'b0;
        #1;
        chk("ex_stall3", {31'd0, Stall}, 32'd1);
        chk("ex_pcsel3", {31'd0, PCSelJr}, 32'd0);
        tick();
        clr_in();
        #1;
        chk("ex_pcsel4", {31'd0, PCSelJr}, 32'd1);
        chk("ex_stall4", {31'd0, Stall}, 32'd0);
        chk("ex_target", JrTarget, 32'h0040_0200);
        chk("ex_cnt", {16'd0, JrStallCnt}, 32'd3);

        // rs = 0 never hazards even if EX writes r0.
        do_reset();
        tick();
        jr(5'd0, 32'h1234_5678);
        RegWrite_EX = 1'b1;
        WriteReg_EX = 5'd0;
        #1;
        chk("r0_stall", {31'd0, Stall}, 32'd1);
        tick();
        clr_in();
        #1;
        chk("r0_pcsel", {31'd0, PCSelJr}, 32'd1);
        chk("r0_target", JrTarget, 32'h1234_5678);
        chk("r0_cnt", {16'd0, JrStallCnt}, 32'd1);

        // Misaligned target, then a back-to-back aligned jr.
        do_reset();
        tick();
        jr(5'd7, 32'h0000_1002);
        #1;
        chk("ma_aerr0", {31'd0, JrAddrErr}, 32'd0);
        tick();
        jr(5'd7, 32'h0000_2000);  // ignored while in REDIR
        #1;
        chk("ma_pcsel", {31'd0, PCSelJr}, 32'd1);
        chk("ma_target", JrTarget, 32'h0000_1000);
        chk("ma_aerr", {31'd0, JrAddrErr}, 32'd1);
        chk("ma_stall_r", {31'd0, Stall}, 32'd0);
        tick();
        #1;
        chk("b2b_stall", {31'd0, Stall}, 32'd1);
        chk("b2b_aerr0", {31'd0, JrAddrErr}, 32'd0);
        chk("b2b_pcsel0", {31'd0, PCSelJr}, 32'd0);
        chk("b2b_hold", JrTarget, 32'h0000_1000);
        tick();
        clr_in();
        #1;
        chk("b2b_pcsel", {31'd0, PCSelJr}, 32'd1);
        chk("b2b_target", JrTarget, 32'h0000_2000);
        chk("b2b_aerr", {31'd0, JrAddrErr}, 32'd0);
        chk("b2b_cnt", {16'd0, JrStallCnt}, 32'd2);

        // Reset in the middle of WAIT cancels everything.
        tick();
        jr(5'd9, 32'h0000_3000);
        RegWrite_MEM = 1'b1;
        WriteReg_MEM = 5'd9;
        tick();
        #1;
        chk("rw_wait_stall", {31'd0, Stall}, 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("rw_stall", {31'd0, Stall}, 32'd0);
        chk("rw_pcsel", {31'd0, PCSelJr}, 32'd0);
        chk("rw_flush", {31'd0, Flush_IFID}, 32'd0);
        chk("rw_cnt", {16'd0, JrStallCnt}, 32'd0);
        chk("rw_target", JrTarget, 32'd0);
        clr_in();
        #2;
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rw_no_redir", {31'd0, PCSelJr}, 32'd0);
        end

        // Taken branch alongside a jr in IDLE: jr ignored.
        tick();
        jr(5'd5, 32'h0000_4000);
        BranchTaken_EX = 1'b1;
        #1;
        chk("br_idle_stall", {31'd0, Stall}, 32'd0);
        tick();
        clr_in();
        #1;
        chk("br_idle_pcsel", {31'd0, PCSelJr}, 32'd0);
        chk("br_idle_cnt", {16'd0, JrStallCnt}, 32'd0);

        // Taken branch while in WAIT aborts.
        jr(5'd5, 32'h0000_5000);
        RegWrite_EX = 1'b1;
        WriteReg_EX = 5'd5;
        tick();
        BranchTaken_EX = 1'b1;
        #1;
        chk("br_wait_stall", {31'd0, Stall}, 32'd0);
        tick();
        clr_in();
        #1;
        chk("br_wait_pcsel", {31'd0, PCSelJr}, 32'd0);
        chk("br_wait_cnt", {16'd0, JrStallCnt}, 32'd1);
        chk("br_wait_target", JrTarget, 32'd0);

        // Saturation: hold in WAIT for more than 65535 stall cycles.
        do_reset();
        tick();
        jr(5'd5, 32'h0000_6000);
        RegWrite_EX = 1'b1;
        WriteReg_EX = 5'd5;
        repeat (65534) @(posedge Clk);
        #1;
        chk("sat_fffe", {16'd0, JrStallCnt}, 32'h0000_FFFE);
        tick();
        tick();
        chk("sat_ffff", {16'd0, JrStallCnt}, 32'h0000_FFFF);
        tick();
        chk("sat_hold", {16'd0, JrStallCnt}, 32'h0000_FFFF);
        chk("sat_stall", {31'd0, Stall}, 32'd1);
        RegWrite_EX = 1'b0;
        tick();
        clr_in();
        #1;
        chk("sat_pcsel", {31'd0, PCSelJr}, 32'd1);
        chk("sat_target", JrTarget, 32'h0000_6000);
        chk("sat_final", {16'd0, JrStallCnt}, 32'h0000_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
